fifo_rd_ctrl: RTL and testbench

//   Read-side control of the async FIFO; partner of the write-side controller.
//   - Runs entirely in the read clock domain.
//   - Keeps the binary read pointer and drives the memory read address.
//   - Publishes a registered Gray read pointer for the 2-FF sync into the write domain.
//   - Takes the synchronized Gray write pointer and derives EMPTY, ALMOST-EMPTY, fill level and sticky underflow.

---
 rtl/fifo_rd_ctrl.sv | 84 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: binary/Gray read pointer, memory read
// address, and empty / almost-empty / level / sticky-underflow status from the synced write pointer.
module fifo_rd_ctrl #(
    parameter int MEM_DEPTH  = 8,
    parameter int PTR_SIZE   = $clog2(MEM_DEPTH) + 1,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  R_CLK,
    input  logic                  R_RST_n,
    input  logic                  R_INC,
    input  logic [PTR_SIZE-1:0]   RQ2_W_PTR,
    output logic                  R_EMPTY,
    output logic                  R_AEMPTY,
    output logic [PTR_SIZE-1:0]   R_LEVEL,
    output logic                  R_UNDERFLOW,
    output logic [PTR_SIZE-1:0]   R_PTR,
    output logic [ADDR_WIDTH-1:0] R_ADDR
);

    localparam logic [PTR_SIZE-1:0] AEMPTY_THR = PTR_SIZE'(AEMPTY_LVL);

    function automatic logic [PTR_SIZE-1:0] bin2gray(input logic [PTR_SIZE-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_SIZE-1:0] gray2bin(input logic [PTR_SIZE-1:0] g);
        logic [PTR_SIZE-1:0] b;
        b[PTR_SIZE-1] = g[PTR_SIZE-1];
        for (int i = PTR_SIZE - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_SIZE-1:0] r_bin;
    logic [PTR_SIZE-1:0] r_ptr;
    logic [PTR_SIZE-1:0] r_level;
    logic                r_empty;
    logic                r_aempty;
    logic                r_underflow;

    logic                w_pop;
    logic                w_underrun;
    logic [PTR_SIZE-1:0] w_bin_nxt;
    logic [PTR_SIZE-1:0] w_gray_nxt;
    logic [PTR_SIZE-1:0] w_wbin;
    logic [PTR_SIZE-1:0] w_level_nxt;

    // Pops are gated by the registered empty flag, which is pessimistic by design.
    assign w_pop       = R_INC & ~r_empty;
    assign w_underrun  = R_INC &  r_empty;
    assign w_bin_nxt   = r_bin + {{(PTR_SIZE-1){1'b0}}, w_pop};
    assign w_gray_nxt  = bin2gray(w_bin_nxt);
    assign w_wbin      = gray2bin(RQ2_W_PTR);
    assign w_level_nxt = w_wbin - w_bin_nxt;

    always_ff @(posedge R_CLK) begin
        if (!R_RST_n) begin
            r_bin       <= '0;
            r_ptr       <= '0;
            r_level     <= '0;
            r_empty     <= 1'b1;
            r_aempty    <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_bin       <= w_bin_nxt;
            r_ptr       <= w_gray_nxt;
            r_level     <= w_level_nxt;
            r_empty     <= (w_gray_nxt == RQ2_W_PTR);
            r_aempty    <= (w_level_nxt <= AEMPTY_THR);
            r_underflow <= r_underflow | w_underrun;
        end
    end

    // Asynchronous memory read: the head entry is addressed straight from the binary pointer.
    assign R_ADDR      = r_bin[ADDR_WIDTH-1:0];
    assign R_PTR       = r_ptr;
    assign R_LEVEL     = r_level;
    assign R_EMPTY     = r_empty;
    assign R_AEMPTY    = r_aempty;
    assign R_UNDERFLOW = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed vector table, a wrap sequence, and random traffic
// checked against a count-based model of the FIFO occupancy.
module tb_fifo_rd_ctrl;

    localparam int MEM_DEPTH = 8;
    localparam int PTR_SIZE  = 4;
    localparam int ADDR_W    = 3;

    logic                R_CLK = 1'b0;
    logic                R_RST_n;
    logic                R_INC;
    logic [PTR_SIZE-1:0] RQ2_W_PTR;
    logic                R_EMPTY;
    logic                R_AEMPTY;
    logic [PTR_SIZE-1:0] R_LEVEL;
    logic                R_UNDERFLOW;
    logic [PTR_SIZE-1:0] R_PTR;
    logic [ADDR_W-1:0]   R_ADDR;

    int total = 0;
    int bad   = 0;

    fifo_rd_ctrl #(.MEM_DEPTH(MEM_DEPTH), .AEMPTY_LVL(2)) dut (
        .R_CLK(R_CLK), .R_RST_n(R_RST_n), .R_INC(R_INC), .RQ2_W_PTR(RQ2_W_PTR),
        .R_EMPTY(R_EMPTY), .R_AEMPTY(R_AEMPTY), .R_LEVEL(R_LEVEL),
        .R_UNDERFLOW(R_UNDERFLOW), .R_PTR(R_PTR), .R_ADDR(R_ADDR)
    );

    always #5 R_CLK = ~R_CLK;

    typedef struct {
        logic       rst_n;
        logic       inc;
        logic [3:0] wptr;
        logic       e_empty;
        logic       e_aempty;
        int         e_level;
        logic       e_uf;
        logic [3:0] e_ptr;
        int         e_addr;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge R_CLK);
        #1;
    endtask

    function automatic logic [3:0] gray(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    vec_t vecs[13];
    logic [3:0] prev_ptr;

    // Random-phase model: plain write/read counts; occupancy is their difference.
    int  w_cnt, rd_cnt, m_level;
    logic m_empty, m_uf, inc_r;

    initial begin
        R_RST_n = 1'b0; R_INC = 1'b0; RQ2_W_PTR = '0;

        //           rst  inc  wptr     E  AE  L  UF  PTR     ADDR
        vecs[0]  = '{1'b0, 1'b0, 4'b0000, 1, 1, 0, 0, 4'b0000, 0};
        vecs[1]  = '{1'b1, 1'b0, 4'b0010, 0, 0, 3, 0, 4'b0000, 0};
        vecs[2]  = '{1'b1, 1'b1, 4'b0010, 0, 1, 2, 0, 4'b0001, 1};
        vecs[3]  = '{1'b1, 1'b1, 4'b0010, 0, 1, 1, 0, 4'b0011, 2};
        vecs[4]  = '{1'b1, 1'b1, 4'b0010, 1, 1, 0, 0, 4'b0010, 3};
        vecs[5]  = '{1'b1, 1'b1, 4'b0010, 1, 1, 0, 1, 4'b0010, 3};
        vecs[6]  = '{1'b1, 1'b0, 4'b0111, 0, 1, 2, 1, 4'b0010, 3};
        vecs[7]  = '{1'b1, 1'b1, 4'b0111, 0, 1, 1, 1, 4'b0110, 4};
        vecs[8]  = '{1'b1, 1'b0, 4'b1101, 0, 0, 5, 1, 4'b0110, 4};
        vecs[9]  = '{1'b0, 1'b1, 4'b1101, 1, 1, 0, 0, 4'b0000, 0};
        vecs[10] = '{1'b1, 1'b0, 4'b1100, 0, 0, 8, 0, 4'b0000, 0};
        vecs[11] = '{1'b1, 1'b1, 4'b1101, 0, 0, 8, 0, 4'b0001, 1};
        vecs[12] = '{1'b1, 1'b0, 4'b1101, 0, 0, 8, 0, 4'b0001, 1};

        foreach (vecs[i]) begin
            R_RST_n = vecs[i].rst_n; R_INC = vecs[i].inc; RQ2_W_PTR = vecs[i].wptr;
            tick();
            chk($sformatf("v%0d.empty", i),  int'(R_EMPTY),     int'(vecs[i].e_empty));
            chk($sformatf("v%0d.aempty", i), int'(R_AEMPTY),    int'(vecs[i].e_aempty));
            chk($sformatf("v%0d.level", i),  int'(R_LEVEL),     vecs[i].e_level);
            chk($sformatf("v%0d.uf", i),     int'(R_UNDERFLOW), int'(vecs[i].e_uf));
            chk($sformatf("v%0d.ptr", i),    int'(R_PTR),       int'(vecs[i].e_ptr));
            chk($sformatf("v%0d.addr", i),   int'(R_ADDR),      vecs[i].e_addr);
        end

        // Wrap: 16 single-entry writes, each popped; pointer must lap back to zero.
        R_RST_n = 1'b0; R_INC = 1'b0; RQ2_W_PTR = '0;
        tick();
        R_RST_n = 1'b1;
        prev_ptr = R_PTR;
        for (int k = 1; k <= 16; k++) begin
            RQ2_W_PTR = gray(k); R_INC = 1'b0;
            tick();
            chk($sformatf("wrap%0d.level", k), int'(R_LEVEL), 1);
            R_INC = 1'b1;
            tick();
            chk($sformatf("wrap%0d.addr", k), int'(R_ADDR), k % MEM_DEPTH);
            chk($sformatf("wrap%0d.onebit", k), $countones(R_PTR ^ prev_ptr), 1);
            chk($sformatf("wrap%0d.empty", k), int'(R_EMPTY), 1);
            chk($sformatf("wrap%0d.lvlmax", k), int'(R_LEVEL <= 4'd8), 1);
            prev_ptr = R_PTR;
        end
        chk("wrap.ptr_home", int'(R_PTR), 0);
        R_INC = 1'b0;

        // Random traffic with occasional resets.
        R_RST_n = 1'b0; RQ2_W_PTR = '0;
        tick();
        w_cnt = 0; rd_cnt = 0; m_level = 0; m_empty = 1'b1; m_uf = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                R_RST_n = 1'b0; R_INC = 1'($urandom_range(0, 1));
                w_cnt = 0; rd_cnt = 0; RQ2_W_PTR = '0;
                tick();
                m_level = 0; m_empty = 1'b1; m_uf = 1'b0;
            end else begin
                R_RST_n = 1'b1;
                R_INC = ($urandom_range(0, 99) < 45);
                if ((w_cnt - rd_cnt) < MEM_DEPTH && $urandom_range(0, 99) < 50) w_cnt++;
                RQ2_W_PTR = gray(w_cnt);
                inc_r = R_INC;
                tick();
                if (inc_r && m_empty) m_uf = 1'b1;
                if (inc_r && !m_empty) rd_cnt++;
                m_level = w_cnt - rd_cnt;
                m_empty = (m_level == 0);
            end
            chk("rnd.empty",  int'(R_EMPTY),     int'(m_empty));
            chk("rnd.aempty", int'(R_AEMPTY),    int'(m_level <= 2));
            chk("rnd.level",  int'(R_LEVEL),     m_level);
            chk("rnd.uf",     int'(R_UNDERFLOW), int'(m_uf));
            chk("rnd.ptr",    int'(R_PTR),       int'(gray(rd_cnt)));
            chk("rnd.addr",   int'(R_ADDR),      rd_cnt % MEM_DEPTH);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
